// File: rtl/cpu.sv
// cpu: multi-cycle 32-bit load/store core sharing one word-addressed memory port
// for fetch and data. Defining CPU_MUL_EN enables the MUL instruction (opcode 0x10).
module cpu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic [15:0] addr,
    output logic        rw
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_MEM   = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_XOR  = 6'h05;
    localparam logic [5:0] OP_SHL  = 6'h06;
    localparam logic [5:0] OP_SHR  = 6'h07;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LUI  = 6'h09;
    localparam logic [5:0] OP_LD   = 6'h0A;
    localparam logic [5:0] OP_ST   = 6'h0B;
    localparam logic [5:0] OP_BEQ  = 6'h0C;
    localparam logic [5:0] OP_BNE  = 6'h0D;
    localparam logic [5:0] OP_JMP  = 6'h0E;
    localparam logic [5:0] OP_HALT = 6'h0F;
`ifdef CPU_MUL_EN
    localparam logic [5:0] OP_MUL  = 6'h10;
`endif

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] regs_q [8];
    logic [31:0] regs_d [8];

    logic [5:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [15:0] imm;
    logic [31:0] simm;
    logic [31:0] rd_val, rs1_val, rs2_val;
    logic [15:0] ea;
    logic [31:0] alu_res;
    logic        alu_wr;
    logic        st_mem;

    assign op      = ir_q[31:26];
    assign rd      = ir_q[25:23];
    assign rs1     = ir_q[22:20];
    assign rs2     = ir_q[19:17];
    assign imm     = ir_q[15:0];
    assign simm    = {{16{imm[15]}}, imm};
    assign rd_val  = regs_q[rd];
    assign rs1_val = regs_q[rs1];
    assign rs2_val = regs_q[rs2];
    // Only the low 16 bits of rs1+simm form the address, so a 16-bit add suffices.
    assign ea      = rs1_val[15:0] + imm;

    always_comb begin
        alu_res = '0;
        alu_wr  = 1'b0;
        case (op)
            OP_ADD:  begin alu_res = rs1_val + rs2_val;        alu_wr = 1'b1; end
            OP_SUB:  begin alu_res = rs1_val - rs2_val;        alu_wr = 1'b1; end
            OP_AND:  begin alu_res = rs1_val & rs2_val;        alu_wr = 1'b1; end
            OP_OR:   begin alu_res = rs1_val | rs2_val;        alu_wr = 1'b1; end
            OP_XOR:  begin alu_res = rs1_val ^ rs2_val;        alu_wr = 1'b1; end
            OP_SHL:  begin alu_res = rs1_val << rs2_val[4:0];  alu_wr = 1'b1; end
            OP_SHR:  begin alu_res = rs1_val >> rs2_val[4:0];  alu_wr = 1'b1; end
            OP_ADDI: begin alu_res = rs1_val + simm;           alu_wr = 1'b1; end
            OP_LUI:  begin alu_res = {imm, 16'h0000};          alu_wr = 1'b1; end
`ifdef CPU_MUL_EN
            OP_MUL:  begin alu_res = rs1_val * rs2_val;        alu_wr = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
        end
        case (state_q)
            S_FETCH: begin
                ir_d    = din;
                pc_d    = pc_q + 16'd1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (alu_wr) begin
                    regs_d[rd] = alu_res;
                end
                case (op)
                    OP_BEQ:  if (rd_val == rs1_val) pc_d = pc_q + imm;
                    OP_BNE:  if (rd_val != rs1_val) pc_d = pc_q + imm;
                    OP_JMP:  pc_d = imm;
                    OP_LD,
                    OP_ST:   state_d = S_MEM;
                    OP_HALT: state_d = S_HALT;
                    default: ;
                endcase
            end
            S_MEM: begin
                if (op == OP_LD) begin
                    regs_d[rd] = din;
                end
                state_d = S_FETCH;
            end
            default: ;
        endcase
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reset gates the write strobe combinationally so memory is safe mid-store.
    assign st_mem = (state_q == S_MEM) && (op == OP_ST);
    assign rw     = ~(rst & st_mem);
    assign addr   = (state_q == S_MEM) ? ea : pc_q;
    assign dout   = st_mem ? rd_val : 32'h0;

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: bus-cycle checker for cpu against an instruction-level reference model,
// plus a table of ALU vectors and hand-written multi-cycle sequences.
module tb_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] din;
    logic [31:0] dout;
    logic [15:0] addr;
    logic        rw;

    logic [31:0] mem  [32768];
    logic [31:0] mmem [32768];
    int vec_count   = 0;
    int err_count   = 0;
    int write_count = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic        rw;
        logic [31:0] dout;
    } bus_t;
    bus_t exp_q[$];

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        string       name;
    } alu_vec_t;

`ifdef CPU_MUL_EN
    localparam logic [31:0] MUL_3X5   = 32'd15;
    localparam logic [31:0] MUL_KEEP  = 32'd0;
`else
    localparam logic [31:0] MUL_3X5   = 32'd0;
    localparam logic [31:0] MUL_KEEP  = 32'h0000_0055;
`endif

    cpu dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout),
        .addr (addr),
        .rw   (rw)
    );

    always #5 clk = ~clk;

    assign din = mem[addr[14:0]];

    always @(posedge clk) begin
        if (!rw) begin
            mem[addr[14:0]] = dout;
            write_count++;
        end
    end

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2,
                                        input logic [15:0] imm);
        return {op, rd, rs1, rs2, 1'b0, imm};
    endfunction

    function automatic bus_t mk(input logic [15:0] a, input logic w, input logic [31:0] d);
        bus_t b;
        b.addr = a;
        b.rw   = w;
        b.dout = d;
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
    endtask

    // Two words: LUI rr,hi ; ADDI rr,rr,lo  giving value v after sign extension of lo.
    task automatic load_imm(input int w, input logic [2:0] rr, input logic [31:0] v);
        logic [15:0] lo;
        logic [31:0] t;
        lo = v[15:0];
        t  = v - {{16{lo[15]}}, lo};
        mem[w]     = enc(6'h09, rr, 3'd0, 3'd0, t[31:16]);
        mem[w + 1] = enc(6'h08, rr, rr, 3'd0, lo);
    endtask

    // Instruction-set model: executes the program and lists the expected bus cycles.
    task automatic model_run(output bit halted);
        logic [31:0] r [8];
        logic [15:0] pc, pcn, ea, imm;
        logic [31:0] ir, a, b, d, simm;
        logic [5:0]  op;
        logic [2:0]  fd, f1, f2;
        exp_q.delete();
        halted = 1'b0;
        for (int i = 0; i < 32768; i++) mmem[i] = mem[i];
        for (int i = 0; i < 8; i++) r[i] = 32'h0;
        pc = 16'h0;
        for (int step = 0; step < 3000 && !halted; step++) begin
            ir   = mmem[pc[14:0]];
            op   = ir[31:26];
            fd   = ir[25:23];
            f1   = ir[22:20];
            f2   = ir[19:17];
            imm  = ir[15:0];
            simm = {{16{imm[15]}}, imm};
            d = r[fd]; a = r[f1]; b = r[f2];
            pcn = pc + 16'd1;
            exp_q.push_back(mk(pc, 1'b1, 32'h0));
            exp_q.push_back(mk(pcn, 1'b1, 32'h0));
            pc = pcn;
            case (op)
                6'h01: r[fd] = a + b;
                6'h02: r[fd] = a - b;
                6'h03: r[fd] = a & b;
                6'h04: r[fd] = a | b;
                6'h05: r[fd] = a ^ b;
                6'h06: r[fd] = a << b[4:0];
                6'h07: r[fd] = a >> b[4:0];
                6'h08: r[fd] = a + simm;
                6'h09: r[fd] = {imm, 16'h0};
                6'h0A: begin
                    ea = a[15:0] + imm;
                    exp_q.push_back(mk(ea, 1'b1, 32'h0));
                    r[fd] = mmem[ea[14:0]];
                end
                6'h0B: begin
                    ea = a[15:0] + imm;
                    exp_q.push_back(mk(ea, 1'b0, d));
                    mmem[ea[14:0]] = d;
                end
                6'h0C: if (d == a) pc = pcn + imm;
                6'h0D: if (d != a) pc = pcn + imm;
                6'h0E: pc = imm;
                6'h0F: begin
                    halted = 1'b1;
                    repeat (4) exp_q.push_back(mk(pcn, 1'b1, 32'h0));
                end
`ifdef CPU_MUL_EN
                6'h10: r[fd] = a * b;
`endif
                default: ;
            endcase
            r[0] = 32'h0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_prog(input string name);
        bit   halted;
        bus_t act;
        model_run(halted);
        if (!halted) begin
            vec_count++;
            err_count++;
            $display("FAIL %s: reference program did not halt within budget", name);
        end
        do_reset();
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(negedge clk);
            act = mk(addr, rw, dout);
            vec_count++;
            if (act !== exp_q[k]) begin
                err_count++;
                $display("FAIL %s cycle %0d: got addr=%h rw=%b dout=%h expected addr=%h rw=%b dout=%h",
                         name, k, act.addr, act.rw, act.dout,
                         exp_q[k].addr, exp_q[k].rw, exp_q[k].dout);
                break;
            end
        end
    endtask

    alu_vec_t vecs [14];

    initial begin
        int  w0;
        bit  frozen;
        logic [5:0]  op;
        logic [2:0]  rd, r1, r2;
        logic [15:0] imm;
        int kind;

        vecs[0]  = '{6'h01, 32'd5,          32'hFFFF_FFFD, 32'd2,          "add"};
        vecs[1]  = '{6'h02, 32'hFFFF_FFFD,  32'd5,         32'hFFFF_FFF8,  "sub"};
        vecs[2]  = '{6'h03, 32'hF0F0_F0F0,  32'hFF00_FF00, 32'hF000_F000,  "and"};
        vecs[3]  = '{6'h04, 32'hF0F0_F0F0,  32'hFF00_FF00, 32'hFFF0_FFF0,  "or"};
        vecs[4]  = '{6'h05, 32'hF0F0_F0F0,  32'hFF00_FF00, 32'h0FF0_0FF0,  "xor"};
        vecs[5]  = '{6'h06, 32'd1,          32'd31,        32'h8000_0000,  "shl31"};
        vecs[6]  = '{6'h06, 32'd3,          32'd33,        32'd6,          "shl_mask"};
        vecs[7]  = '{6'h07, 32'h8000_0000,  32'd31,        32'd1,          "shr31"};
        vecs[8]  = '{6'h07, 32'hFFFF_FFFF,  32'd4,         32'h0FFF_FFFF,  "shr_logical"};
        vecs[9]  = '{6'h01, 32'hFFFF_FFFF,  32'd1,         32'd0,          "add_wrap"};
        vecs[10] = '{6'h10, 32'h0001_0000,  32'h0001_0000, 32'd0,          "mul_overflow"};
        vecs[11] = '{6'h10, 32'd3,          32'd5,         MUL_3X5,        "mul_3x5"};
        vecs[12] = '{6'h3F, 32'd7,          32'd9,         32'd0,          "undef_nop"};
        vecs[13] = '{6'h00, 32'd7,          32'd9,         32'd0,          "nop"};

        // Reset state
        clear_mem();
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_held", {addr, rw, dout}, {16'h0, 1'b1, 32'h0});
        rst = 1'b1;
        #1;
        check("reset_release", {addr, rw, dout}, {16'h0, 1'b1, 32'h0});

        // ALU table
        for (int v = 0; v < 14; v++) begin
            clear_mem();
            load_imm(0, 3'd1, vecs[v].a);
            load_imm(2, 3'd2, vecs[v].b);
            mem[4] = enc(vecs[v].op, 3'd3, 3'd1, 3'd2, 16'h0);
            mem[5] = enc(6'h0B, 3'd3, 3'd0, 3'd0, 16'h0100);
            mem[6] = enc(6'h0F, 3'd0, 3'd0, 3'd0, 16'h0);
            run_prog(vecs[v].name);
            check(vecs[v].name, mem[256], vecs[v].res);
        end

        // LUI / ST / LD round trip, one write cycle per store
        clear_mem();
        mem[0] = enc(6'h09, 3'd1, 3'd0, 3'd0, 16'h1234);
        mem[1] = enc(6'h0B, 3'd1, 3'd0, 3'd0, 16'h0100);
        mem[2] = enc(6'h0A, 3'd5, 3'd0, 3'd0, 16'h0100);
        mem[3] = enc(6'h0B, 3'd5, 3'd0, 3'd0, 16'h0101);
        mem[4] = enc(6'h0F, 3'd0, 3'd0, 3'd0, 16'h0);
        w0 = write_count;
        run_prog("lui_st_ld");
        check("st_word", mem[256], 32'h1234_0000);
        check("ld_value", mem[257], 32'h1234_0000);
        check("st_write_cycles", 64'(write_count - w0), 64'd2);

        // BNE loop, then frozen HALT
        clear_mem();
        mem[0] = enc(6'h08, 3'd1, 3'd0, 3'd0, 16'd3);
        mem[1] = enc(6'h08, 3'd1, 3'd1, 3'd0, 16'hFFFF);
        mem[2] = enc(6'h0B, 3'd1, 3'd0, 3'd0, 16'h0180);
        mem[3] = enc(6'h0D, 3'd1, 3'd0, 3'd0, 16'hFFFD);
        mem[4] = enc(6'h0F, 3'd0, 3'd0, 3'd0, 16'h0);
        mem[384] = 32'hFFFF_FFFF;
        w0 = write_count;
        run_prog("bne_loop");
        check("loop_iterations", 64'(write_count - w0), 64'd3);
        check("loop_final", mem[384], 32'h0);
        frozen = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (addr !== 16'd5 || rw !== 1'b1 || dout !== 32'h0) frozen = 1'b0;
        end
        check("halt_frozen", {63'h0, frozen}, 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("reset_from_halt", {addr, rw, dout}, {16'h0, 1'b1, 32'h0});

        // r0 is hard-wired zero
        clear_mem();
        mem[0] = enc(6'h08, 3'd0, 3'd0, 3'd0, 16'd7);
        mem[1] = enc(6'h0B, 3'd0, 3'd0, 3'd0, 16'h0101);
        mem[2] = enc(6'h0F, 3'd0, 3'd0, 3'd0, 16'h0);
        mem[257] = 32'hDEAD_BEEF;
        run_prog("r0_write");
        check("r0_store", mem[257], 32'h0);

        // MUL of 0x10000 x 0x10000 into a preloaded r3
        clear_mem();
        load_imm(0, 3'd1, 32'h0001_0000);
        load_imm(2, 3'd2, 32'h0001_0000);
        mem[4] = enc(6'h08, 3'd3, 3'd0, 3'd0, 16'h0055);
        mem[5] = enc(6'h10, 3'd3, 3'd1, 3'd2, 16'h0);
        mem[6] = enc(6'h0B, 3'd3, 3'd0, 3'd0, 16'h0100);
        mem[7] = enc(6'h0F, 3'd0, 3'd0, 3'd0, 16'h0);
        run_prog("mul_spec");
        check("mul_spec_r3", mem[256], MUL_KEEP);

        // Store rewrites a later instruction before it is fetched
        clear_mem();
        load_imm(0, 3'd1, enc(6'h08, 3'd2, 3'd0, 3'd0, 16'd9));
        mem[2] = enc(6'h0B, 3'd1, 3'd0, 3'd0, 16'd4);
        mem[3] = 32'h0;
        mem[4] = enc(6'h0F, 3'd0, 3'd0, 3'd0, 16'h0);
        mem[5] = enc(6'h0B, 3'd2, 3'd0, 3'd0, 16'h0102);
        mem[6] = enc(6'h0F, 3'd0, 3'd0, 3'd0, 16'h0);
        run_prog("self_modify");
        check("self_modify_result", mem[258], 32'd9);

        // Reset asserted during the write cycle of a store
        clear_mem();
        mem[0] = enc(6'h09, 3'd1, 3'd0, 3'd0, 16'hABCD);
        mem[1] = enc(6'h0B, 3'd1, 3'd0, 3'd0, 16'h0103);
        mem[2] = enc(6'h0F, 3'd0, 3'd0, 3'd0, 16'h0);
        do_reset();
        repeat (4) @(negedge clk);
        check("st_mem_cycle", {addr, rw, dout}, {16'h0103, 1'b0, 32'hABCD_0000});
        rst = 1'b0;
        #1;
        check("rw_forced_in_reset", {63'h0, rw}, 64'd1);
        @(negedge clk);
        check("reset_mid_store", {addr, rw, dout}, {16'h0, 1'b1, 32'h0});
        check("no_write_in_reset", mem[259], 32'h0);

        // Random programs: forward-only control flow, data in 0x200..0x2FF
        for (int p = 0; p < 10; p++) begin
            clear_mem();
            for (int j = 0; j < 256; j++) mem[512 + j] = $urandom;
            for (int i = 0; i < 40; i++) begin
                kind = $urandom_range(0, 11);
                rd  = 3'($urandom);
                r1  = 3'($urandom);
                r2  = 3'($urandom);
                imm = 16'($urandom);
                case (kind)
                    0, 1, 2, 3: op = 6'($urandom_range(1, 7));
                    4:          op = 6'h10;
                    5, 6:       op = 6'h08;
                    7:          op = 6'h09;
                    8: begin
                        op  = ($urandom_range(0, 1) != 0) ? 6'h0A : 6'h0B;
                        r1  = 3'd0;
                        imm = 16'(16'h0200 + $urandom_range(0, 255));
                    end
                    9: begin
                        op  = ($urandom_range(0, 1) != 0) ? 6'h0C : 6'h0D;
                        imm = 16'($urandom_range(0, 3));
                    end
                    10: begin
                        op  = 6'h0E;
                        imm = 16'(i + 1 + $urandom_range(0, 3));
                    end
                    default: op = ($urandom_range(0, 1) != 0) ? 6'h00 : 6'($urandom_range(17, 63));
                endcase
                mem[i] = {op, rd, r1, r2, 1'($urandom), imm};
            end
            for (int i = 40; i < 48; i++) mem[i] = enc(6'h0F, 3'd0, 3'd0, 3'd0, 16'h0);
            run_prog($sformatf("random%0d", p));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule

// File: doc/cpu.md
# cpu

Multi-cycle 32-bit load/store processor core with a single word-addressed memory port. It fetches 32-bit instructions and data through the same asynchronous-read, synchronous-write memory, and holds eight 32-bit registers and a 16-bit program counter. It is the top-level compute block; the memory and the testbench clock/reset sit outside it.

## Interface
- No parameters.
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous active-low reset.
- din  input  32  memory read data; combinational function of addr, valid in the same cycle.
- dout  output  32  memory write data.
- addr  output  16  word address to memory; memory decodes only [14:0].
- rw  output  1  1 = read, 0 = write; memory writes dout at the clock edge when rw = 0.

## Operation
- Registers r0–r7, 32 bit; r0 reads 0, writes are discarded. PC is 16 bit, word-addressed.
- Instruction fields: op[31:26], rd[25:23], rs1[22:20], rs2[19:17], imm[15:0]; simm = sign-extended imm.
- ALU ops write rd:
  - 0x01 ADD rs1+rs2, 0x02 SUB rs1−rs2, 0x03 AND, 0x04 OR, 0x05 XOR.
  - 0x06 SHL rs1<<rs2[4:0], 0x07 SHR (logical) rs1>>rs2[4:0].
  - 0x08 ADDI rs1+simm, 0x09 LUI imm<<16.
- Memory ops use EA = (rs1+simm)[15:0]: 0x0A LD rd=mem[EA]; 0x0B ST mem[EA]=rd.
- Control:
  - 0x0C BEQ: if rd==rs1, PC=PC_next+simm (mod 2^16).
  - 0x0D BNE: same target, taken when rd!=rs1.
  - 0x0E JMP: PC=imm.
  - 0x0F HALT.
- 0x00 and all undefined opcodes execute as NOP.
- All arithmetic is 32-bit modulo 2^32; no flags, no traps. PC increments by 1 and wraps 0xFFFF→0x0000.
- States:
  - FETCH: IR←din, PC←PC+1; → EXEC.
  - EXEC: ALU writeback, branch or jump resolves. → MEM for LD/ST, → HALT for HALT, otherwise → FETCH.
  - MEM: LD writes rd from din; ST drives write. → FETCH.
  - HALT: stays in HALT until reset.

## Timing
- Latency: ALU, branch, JMP and NOP take 2 cycles (FETCH+EXEC). LD and ST take 3 cycles.
- Register writes are visible to the next instruction; no hazards exist.
- addr = EA in MEM, PC in every other state. Branch offsets are relative to the already-incremented PC.
- rw = 0 only in MEM of ST. rw is combinationally forced to 1 whenever rst = 0, so no write can occur during reset.
- dout = rd value in MEM of ST, 0 otherwise.
- Reset at any edge, including mid-instruction or in HALT: PC=0, registers=0, IR=0, state=FETCH. Resulting outputs: addr=0, rw=1, dout=0.
- ST to the address of a later instruction takes effect; that instruction fetches the new word.

## Configuration
- CPU_MUL_EN defined: opcode 0x10 MUL writes rd = low 32 bits of rs1*rs2, 2 cycles.
- CPU_MUL_EN undefined: 0x10 executes as NOP.

## Test plan
- Reset: hold rst=0 for 2 edges, release → addr=0, rw=1, dout=0, first fetch from word 0.
- ADDI r1,r0,5; ADDI r2,r0,−3; ADD r3,r1,r2 → r3=2. SUB r4,r2,r1 → 0xFFFFFFF8.
- LUI r1,0x1234; ST r1→[r0+0x100]; LD r5←[r0+0x100] → memory word 0x100 = 0x12340000, r5 equal, rw low for exactly one cycle.
- BNE loop decrementing r1 from 3 to 0, then HALT → loop body runs 3 times; addr frozen at HALT PC+1, rw=1 forever.
- Write r0 via ADDI r0,r0,7, then ST r0 → stored value 0.
- MUL r3,r1,r2 with 0x10000×0x10000 → 0 with CPU_MUL_EN defined; r3 unchanged without it.
